// File: rtl/adc128s_pkg.sv
// Shared sizes and types for the ADC128S SPI A2D model.
package adc128s_pkg;
    localparam int NUM_CH     = 8;
    localparam int FRAME_BITS = 16;
    localparam int CH_MSB     = 13;
    localparam int CH_LSB     = 11;
    localparam int DATA_W     = 12;

    typedef logic [2:0] ch_t;
endpackage

// File: rtl/spi_slave16.sv
// 16-bit SPI slave: synchronizers, SCLK/SS_n edge detect, shift register, bit counter.
// Latency: MISO MSB 3 clk after SS_n fall, next bit 3 clk after each SCLK rise.
// Backpressure: none, the master owns timing; partial frames never raise frame_done.
module spi_slave16
    import adc128s_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic [FRAME_BITS-1:0] load_dat,
    output logic                  frame_start,
    output logic                  frame_done,
    output ch_t                   rx_ch,
    output logic                  miso
);
    localparam logic [4:0] FULL = 5'(FRAME_BITS);

    logic [2:0]            ss_sync;
    logic [2:0]            sclk_sync;
    logic [1:0]            mosi_sync;
    logic [FRAME_BITS-1:0] shreg;
    logic [4:0]            bitcnt;
    logic                  frame_end;
    logic                  sclk_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[1:0], ss_n};
            sclk_sync <= {sclk_sync[1:0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign frame_start = ss_sync[2] & ~ss_sync[1];
    assign frame_end   = ~ss_sync[2] & ss_sync[1];
    // Only rises inside a frame count; SCLK activity while deselected is ignored.
    assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2] & ~ss_sync[2];
    assign frame_done  = frame_end && (bitcnt == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (frame_start) begin
            shreg  <= load_dat;
            bitcnt <= '0;
        end else if (sclk_rise) begin
            shreg  <= {shreg[FRAME_BITS-2:0], mosi_sync[1]};
            if (bitcnt != FULL)
                bitcnt <= bitcnt + 5'd1;
        end
    end

    assign rx_ch = shreg[CH_MSB:CH_LSB];
    assign miso  = shreg[FRAME_BITS-1] & ~ss_sync[2];
endmodule

// File: rtl/adc128s.sv
// ADC128S model: 8 self-decrementing channel values served over 16-bit SPI frames.
// Latency: channel pointer and value update 3 clk after SS_n rise.
// Backpressure: none; an aborted frame leaves all channel state untouched.
module adc128s
    import adc128s_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE = 12'hC00,
    parameter logic [DATA_W-1:0] STEP = 12'h010
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO
);
    logic [DATA_W-1:0] val [NUM_CH];
    ch_t               ch_ptr;
    ch_t               ret_ch;
    ch_t               rx_ch;
    logic              frame_start;
    logic              frame_done;
    logic [FRAME_BITS-1:0] load_dat;

    assign load_dat = {{(FRAME_BITS-DATA_W){1'b0}}, val[ch_ptr]};

    spi_slave16 u_spi (
        .clk         (clk),
        .rst_n       (rst_n),
        .ss_n        (SS_n),
        .sclk        (SCLK),
        .mosi        (MOSI),
        .load_dat    (load_dat),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .rx_ch       (rx_ch),
        .miso        (MISO)
    );

    // ret_ch remembers which channel this frame returned, so the decrement hits it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++)
                val[i] <= BASE + DATA_W'(i);
            ch_ptr <= '0;
            ret_ch <= '0;
        end else if (frame_done) begin
            val[ret_ch] <= val[ret_ch] - STEP;
            ch_ptr      <= rx_ch;
        end else if (frame_start) begin
            ret_ch <= ch_ptr;
        end
    end
endmodule

// File: tb/tb_adc128s.sv
// Randomized + directed bench for adc128s; two instances (BASE C00 and BASE 000) share one SPI bus.
module tb_adc128s;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ss_n  = 1'b1;
    logic sclk  = 1'b1;
    logic mosi  = 1'b0;
    logic miso_a, miso_b;

    int total = 0;
    int bad   = 0;

    logic [11:0] mv_a [8];
    logic [11:0] mv_b [8];
    int          mptr;

    adc128s #(.BASE(12'hC00), .STEP(12'h010)) dut_a (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso_a));
    adc128s #(.BASE(12'h000), .STEP(12'h010)) dut_b (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv_a[i] = 12'hC00 + 12'(i);
            mv_b[i] = 12'(i);
        end
        mptr = 0;
    endtask

    // Master side of one frame; samples MISO just before each SCLK rise.
    task automatic spi_xfer(input logic [15:0] cmd, input int nbits,
                            output logic [15:0] rx_a, output logic [15:0] rx_b);
        rx_a = '0;
        rx_b = '0;
        ss_n = 1'b0;
        clks(6);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = cmd[15-i];
            clks(6);
            rx_a = {rx_a[14:0], miso_a};
            rx_b = {rx_b[14:0], miso_b};
            sclk = 1'b1;
            clks(6);
        end
        ss_n = 1'b1;
        mosi = 1'b0;
        clks(8);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] cmd, input int nbits,
                             output logic [15:0] rx_a, output logic [15:0] rx_b);
        logic [15:0] exp_a, exp_b;
        exp_a = {4'h0, mv_a[mptr]};
        exp_b = {4'h0, mv_b[mptr]};
        spi_xfer(cmd, nbits, rx_a, rx_b);
        chk({tag, "_a"}, 32'(rx_a), 32'(exp_a >> (16 - nbits)));
        chk({tag, "_b"}, 32'(rx_b), 32'(exp_b >> (16 - nbits)));
        if (nbits == 16) begin
            mv_a[mptr] = mv_a[mptr] - 12'h010;
            mv_b[mptr] = mv_b[mptr] - 12'h010;
            mptr = int'(cmd[13:11]);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [15:0] cmd;
        int          nb;

        model_reset();
        clks(3);
        chk("rst_miso_a", 32'(miso_a), 32'd0);
        chk("rst_miso_b", 32'(miso_b), 32'd0);
        chk("rst_ptr", 32'(dut_a.ch_ptr), 32'd0);
        rst_n = 1'b1;
        clks(5);

        run_frame("first", 16'h0000, 16, ra, rb);
        chk("first_const", 32'(ra), 32'h0C00);
        chk("first_ptr", 32'(dut_a.ch_ptr), 32'd0);
        chk("first_val0", 32'(dut_a.val[0]), 32'hBF0);

        run_frame("cmd5", 16'h2800, 16, ra, rb);
        run_frame("ret5", 16'h0000, 16, ra, rb);
        chk("ret5_const", 32'(ra), 32'h0C05);
        chk("val5", 32'(dut_a.val[5]), 32'hBF5);

        run_frame("cmd4", 16'h2000, 16, ra, rb);
        run_frame("rd4_1", 16'h2000, 16, ra, rb);
        chk("rd4_1_const", 32'(ra), 32'h0C04);
        run_frame("rd4_2", 16'h2000, 16, ra, rb);
        chk("rd4_2_const", 32'(ra), 32'h0BF4);
        chk("rd4_2_wrap", 32'(rb), 32'h0FF4);
        run_frame("rd4_3", 16'h2000, 16, ra, rb);
        chk("rd4_3_const", 32'(ra), 32'h0BE4);

        run_frame("abort", 16'h0000, 8, ra, rb);
        run_frame("after_abort", 16'h0000, 16, ra, rb);
        chk("after_abort_const", 32'(ra), 32'h0BD4);

        // Reset in the middle of a frame
        ss_n = 1'b0;
        clks(6);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b0; mosi = 1'b1; clks(6);
            sclk = 1'b1; clks(6);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_miso_a", 32'(miso_a), 32'd0);
        chk("midrst_miso_b", 32'(miso_b), 32'd0);
        ss_n = 1'b1;
        sclk = 1'b1;
        mosi = 1'b0;
        clks(3);
        rst_n = 1'b1;
        model_reset();
        clks(5);
        run_frame("post_rst", 16'h3000, 16, ra, rb);
        chk("post_rst_const", 32'(ra), 32'h0C00);

        // SCLK toggling while deselected must be inert
        for (int i = 0; i < 20; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            clks(5);
            chk("idle_miso", 32'(miso_a | miso_b), 32'd0);
        end
        sclk = 1'b1;
        mosi = 1'b0;
        clks(5);
        chk("idle_ptr", 32'(dut_a.ch_ptr), 32'(mptr));
        run_frame("idle_after", 16'h0000, 16, ra, rb);

        for (int k = 0; k < 40; k++) begin
            cmd = 16'($urandom);
            nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16;
            run_frame("rand", cmd, nb, ra, rb);
        end
        chk("final_ptr", 32'(dut_a.ch_ptr), 32'(mptr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
